led_seq: RTL and testbench
==========================

LED_SEQ -- requirements
Module: led_seq

Interface
REQ-001 Parameter N_LEDS, default 4: number of ring LEDs; legal range 2..32.
REQ-002 Parameter DIV_W, default 24: prescaler counter and period width in bits.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 nRst  input  1: reset, asynchronous, active-low.
REQ-005 en  input  1: high lets the prescaler run; low freezes all state.
REQ-006 mode  input  2: pattern select; 0 rotate-cw, 1 rotate-ccw, 2 bounce, 3 blink-all.
REQ-007 period  input  DIV_W: step interval control; a step occurs every period+1 enabled cycles.
REQ-008 led_ring  output  N_LEDS: ring LED drive; bit i high means LED i is lit.
REQ-009 led_mid  output  1: centre LED drive.
REQ-010 step  output  1: one-cycle pulse marking each pattern advance.

Function
REQ-011 The prescaler counter cnt (DIV_W bits) SHALL increment by 1 on each cycle where en=1 and cnt<period.
REQ-012 When en=1 and cnt>=period, the block SHALL set cnt to 0 and register step=1 for exactly one cycle; the >= compare means a period lowered below the current cnt gives a step on the next enabled cycle, with no 2^DIV_W wrap.
REQ-013 period=0 SHALL give a step on every enabled cycle.
REQ-014 en=0 SHALL hold cnt, pos, dir, blink, mode_q and led_mid, and SHALL force step=0.
REQ-015 Internal state SHALL be:
- pos: index 0..N_LEDS-1
- dir: 0 = up, 1 = down
- blink: 1 bit
- mode_q: 2 bits
REQ-016 At each step, mode_q SHALL load mode, and the state advance in that same step SHALL use the newly loaded mode; mode changes between steps SHALL have no effect.
REQ-017 Rotate-cw step: pos+1; from N_LEDS-1 it SHALL wrap to 0 and toggle led_mid.
REQ-018 Rotate-ccw step: pos-1; from 0 it SHALL wrap to N_LEDS-1 and toggle led_mid.
REQ-019 Bounce step with dir=0:
- pos+1
- on reaching N_LEDS-1, SHALL set dir=1 and toggle led_mid
REQ-020 Bounce step with dir=1:
- pos-1
- on reaching 0, SHALL set dir=0 and toggle led_mid
REQ-021 Blink step: SHALL toggle blink and toggle led_mid, and SHALL hold pos and dir.
REQ-022 On a switch into any mode, the pattern SHALL continue from the current pos, dir and blink; no re-centering.
REQ-023 When mode_q is 0, 1 or 2, led_ring SHALL be one-hot at bit pos.
REQ-024 When mode_q is 3, every bit of led_ring SHALL equal blink.
REQ-025 All outputs SHALL be decoded only from registered state; no combinational path from en, mode or period to any output.
REQ-026 For N_LEDS=2, bounce SHALL alternate pos 0,1,0,1 and toggle led_mid on every step.

Reset
REQ-027 While nRst=0, the block SHALL hold, independent of clk: cnt=0, pos=0, dir=0, blink=0, mode_q=0, led_mid=0, step=0.
REQ-028 The output led_ring SHALL read 1 (bit 0 only) during and after reset.
REQ-029 Reset asserted mid-step or mid-count SHALL take effect immediately, with no partial update.
REQ-030 After nRst deasserts, the first step SHALL occur period+1 enabled cycles later.

Verification
REQ-031 Rotate-cw: N_LEDS=4, period=2, mode=0, en=1 -> step every 3 cycles; led_ring 0001,0010,0100,1000,0001; led_mid 0->1 on the 1000->0001 step.
REQ-032 Bounce: mode=2 from reset -> led_ring 0001,0010,0100,1000,0100,0010,0001; led_mid toggles at 1000 and again at 0001.
REQ-033 Mode switch: mode=3 at pos=2 -> led_ring 1111,0000,1111 on successive steps; switching back to mode=0 -> next step gives 1000.
REQ-034 Enable gating: en=0 for 10 cycles mid-count -> cnt, led_ring and led_mid unchanged, step=0; with en=1 restored, counting resumes from the held cnt.
REQ-035 Period shrink: period 100->3 while cnt=50 -> step on the next enabled cycle; subsequent steps every 4 cycles.
REQ-036 Async reset: nRst pulsed low between clock edges with led_ring=0100 and led_mid=1 -> led_ring=0001, led_mid=0 and step=0 before the next rising edge.

Source files
------------

// File: rtl/led_seq_if.sv
// Control and LED-drive bundle for the LED sequencer; clock and reset stay
// outside as plain ports.
interface led_seq_if #(
    parameter int N_LEDS = 4,
    parameter int DIV_W  = 24
);
    logic              en;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  period;
    logic [N_LEDS-1:0] led_ring;
    logic              led_mid;
    logic              step;

    modport master (
        output en, mode, period,
        input  led_ring, led_mid, step
    );

    modport slave (
        input  en, mode, period,
        output led_ring, led_mid, step
    );
endinterface

// File: rtl/led_seq.sv
// LED ring sequencer: a prescaler produces step pulses every period+1 enabled
// cycles, and each step advances a rotate / bounce / blink pattern.
module led_seq #(
    parameter int N_LEDS = 4,
    parameter int DIV_W  = 24
) (
    input  logic     clk,
    input  logic     nRst,
    led_seq_if.slave bus
);
    localparam int PW = $clog2(N_LEDS);
    localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

    typedef enum logic [1:0] {
        M_CW     = 2'd0,
        M_CCW    = 2'd1,
        M_BOUNCE = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    logic [DIV_W-1:0] cnt;
    logic [PW-1:0]    pos;
    logic             dir;
    logic             blink;
    mode_t            mode_q;
    logic             mid;
    logic             step_q;

    logic [PW-1:0]    pos_n;
    logic             dir_n;
    logic             blink_n;
    logic             mid_n;
    logic [PW-1:0]    pos_up;
    logic [PW-1:0]    pos_dn;
    logic             go_up;

    assign pos_up = pos + 1'b1;
    assign pos_dn = pos - 1'b1;
    // A bounce entered at an end with the "wrong" dir reverses instead of
    // running off the ring.
    assign go_up  = (!dir && pos != LAST) || (dir && pos == '0);

    // Next pattern state, decoded from the incoming mode since it is loaded
    // into mode_q on the same step.
    always_comb begin
        pos_n   = pos;
        dir_n   = dir;
        blink_n = blink;
        mid_n   = mid;
        case (mode_t'(bus.mode))
            M_CW: begin
                if (pos == LAST) begin
                    pos_n = '0;
                    mid_n = ~mid;
                end else begin
                    pos_n = pos_up;
                end
            end
            M_CCW: begin
                if (pos == '0) begin
                    pos_n = LAST;
                    mid_n = ~mid;
                end else begin
                    pos_n = pos_dn;
                end
            end
            M_BOUNCE: begin
                if (go_up) begin
                    pos_n = pos_up;
                    dir_n = (pos_up == LAST);
                    if (pos_up == LAST) mid_n = ~mid;
                end else begin
                    pos_n = pos_dn;
                    dir_n = (pos_dn != '0);
                    if (pos_dn == '0) mid_n = ~mid;
                end
            end
            default: begin
                blink_n = ~blink;
                mid_n   = ~mid;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt    <= '0;
            pos    <= '0;
            dir    <= 1'b0;
            blink  <= 1'b0;
            mode_q <= M_CW;
            mid    <= 1'b0;
            step_q <= 1'b0;
        end else if (!bus.en) begin
            step_q <= 1'b0;
        end else if (cnt >= bus.period) begin
            // >= rather than == so a shrunk period steps at once instead of
            // counting all the way round.
            cnt    <= '0;
            step_q <= 1'b1;
            mode_q <= mode_t'(bus.mode);
            pos    <= pos_n;
            dir    <= dir_n;
            blink  <= blink_n;
            mid    <= mid_n;
        end else begin
            cnt    <= cnt + 1'b1;
            step_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ring
        assign bus.led_ring[i] = (mode_q == M_BLINK) ? blink : (pos == PW'(i));
    end

    assign bus.led_mid = mid;
    assign bus.step    = step_q;
endmodule

// File: tb/tb_led_seq.sv
// Self-checking bench for led_seq: table-driven pattern steps scored through
// a queue, plus hand sequences for gating, period changes, reset and N_LEDS=2.
module tb_led_seq;
    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    led_seq_if #(.N_LEDS(4), .DIV_W(24)) bus ();
    led_seq_if #(.N_LEDS(2), .DIV_W(8))  bus2 ();

    led_seq #(.N_LEDS(4), .DIV_W(24)) dut (.clk(clk), .nRst(nRst), .bus(bus));
    led_seq #(.N_LEDS(2), .DIV_W(8))  dut2 (.clk(clk), .nRst(nRst), .bus(bus2));

    typedef struct {
        logic [1:0] mode;
        logic [3:0] ring;
        logic       mid;
    } vec_t;

    typedef struct {
        logic [3:0] ring;
        logic       mid;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[18];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_step(input logic [3:0] ring, input logic mid);
        exp_t e;
        e.ring = ring;
        e.mid  = mid;
        sbq.push_back(e);
    endtask

    // Waits (bounded) for the next step pulse, then scores it against the queue.
    task automatic step_and_check(input string name, input int gap);
        int   cyc;
        bit   ok;
        exp_t e;
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            cyc++;
            ok = bus.step;
        end
        chk({name, " step_seen"}, 32'(ok), 32'd1);
        if (ok) begin
            if (sbq.size() == 0) begin
                chk({name, " sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                chk({name, " ring"}, 32'(bus.led_ring), 32'(e.ring));
                chk({name, " mid"}, 32'(bus.led_mid), 32'(e.mid));
                if (gap > 0) chk({name, " gap"}, 32'(cyc), 32'(gap));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ring_hold;
        logic       mid_hold;
        int         bad;
        logic [1:0] exp_ring2;
        logic       exp_mid2;

        vecs = '{
            '{2'd0, 4'b0010, 1'b0}, '{2'd0, 4'b0100, 1'b0}, '{2'd0, 4'b1000, 1'b0},
            '{2'd0, 4'b0001, 1'b1},
            '{2'd2, 4'b0010, 1'b1}, '{2'd2, 4'b0100, 1'b1}, '{2'd2, 4'b1000, 1'b0},
            '{2'd2, 4'b0100, 1'b0}, '{2'd2, 4'b0010, 1'b0}, '{2'd2, 4'b0001, 1'b1},
            '{2'd1, 4'b1000, 1'b0}, '{2'd1, 4'b0100, 1'b0},
            '{2'd3, 4'b1111, 1'b1}, '{2'd3, 4'b0000, 1'b0}, '{2'd3, 4'b1111, 1'b1},
            '{2'd0, 4'b1000, 1'b1}, '{2'd0, 4'b0001, 1'b0}, '{2'd1, 4'b1000, 1'b1}
        };

        nRst        = 1'b0;
        bus.en      = 1'b0;
        bus.mode    = 2'd0;
        bus.period  = 24'd2;
        bus2.en     = 1'b0;
        bus2.mode   = 2'd2;
        bus2.period = 8'd0;

        #12;
        chk("reset ring", 32'(bus.led_ring), 32'h1);
        chk("reset mid", 32'(bus.led_mid), 32'h0);
        chk("reset step", 32'(bus.step), 32'h0);

        tick();
        nRst   = 1'b1;
        bus.en = 1'b1;

        foreach (vecs[i]) begin
            bus.mode = vecs[i].mode;
            expect_step(vecs[i].ring, vecs[i].mid);
            step_and_check($sformatf("vec%0d", i), 3);
        end

        // Mode wiggle between steps must not reach the outputs.
        bus.mode = 2'd3;
        tick();
        chk("mode_glitch ring", 32'(bus.led_ring), 32'b1000);
        bus.mode = 2'd1;
        expect_step(4'b0100, 1'b1);
        step_and_check("mode_glitch next", 2);

        bus.period = 24'd5;
        bus.mode   = 2'd0;
        tick();
        tick();
        ring_hold = bus.led_ring;
        mid_hold  = bus.led_mid;
        bus.en    = 1'b0;
        bad       = 0;
        repeat (10) begin
            tick();
            if (bus.step !== 1'b0 || bus.led_ring !== ring_hold || bus.led_mid !== mid_hold) bad++;
        end
        chk("gate hold_cycles_bad", 32'(bad), 32'd0);
        bus.en = 1'b1;
        expect_step(4'b1000, 1'b1);
        step_and_check("gate resume", 4);

        bus.period = 24'd100;
        expect_step(4'b0001, 1'b0);
        step_and_check("long_period", 101);
        repeat (50) tick();
        bus.period = 24'd3;
        expect_step(4'b0010, 1'b0);
        step_and_check("shrink first", 1);
        expect_step(4'b0100, 1'b0);
        step_and_check("shrink second", 4);
        expect_step(4'b1000, 1'b0);
        step_and_check("shrink third", 4);
        tick();
        chk("step single_cycle", 32'(bus.step), 32'd0);

        bus.period = 24'd0;
        expect_step(4'b0001, 1'b1);
        step_and_check("period0 a", 1);
        expect_step(4'b0010, 1'b1);
        step_and_check("period0 b", 1);
        expect_step(4'b0100, 1'b1);
        step_and_check("period0 c", 1);

        // Asynchronous reset between edges, observed before the next edge.
        #2;
        nRst = 1'b0;
        #1;
        chk("async ring", 32'(bus.led_ring), 32'h1);
        chk("async mid", 32'(bus.led_mid), 32'h0);
        chk("async step", 32'(bus.step), 32'h0);
        tick();
        tick();
        chk("async hold_ring", 32'(bus.led_ring), 32'h1);
        nRst       = 1'b1;
        bus.period = 24'd2;
        bus.mode   = 2'd0;
        expect_step(4'b0010, 1'b0);
        step_and_check("post_reset first", 3);

        bus2.en   = 1'b1;
        exp_ring2 = 2'b01;
        exp_mid2  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_ring2 = ~exp_ring2;
            exp_mid2  = ~exp_mid2;
            chk($sformatf("n2 step%0d", k), 32'(bus2.step), 32'd1);
            chk($sformatf("n2 ring%0d", k), 32'(bus2.led_ring), 32'(exp_ring2));
            chk($sformatf("n2 mid%0d", k), 32'(bus2.led_mid), 32'(exp_mid2));
        end
        bus2.en = 1'b0;

        chk("sb drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
